// File: rtl/frv_alu_issue.sv
// Execute-stage issue/retire wrapper around the combinational core ALU.
// E1 registers the decoded micro-op and drives the ALU; E2 captures the ALU
// result and compare flags and presents them to writeback.
module frv_alu_issue #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RDW  = 5
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  // Decode side
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [4:0]      s_uop,
  input  logic [XLEN-1:0] s_opr_a,
  input  logic [XLEN-1:0] s_opr_b,
  input  logic [RDW-1:0]  s_rd,
  // Core ALU side
  output logic [XLEN-1:0] alu_opr_a,
  output logic [XLEN-1:0] alu_opr_b,
  output logic [4:0]      alu_shamt,
  output logic [31:0]     alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic [2:0]      alu_cmp,
  // Writeback side
  output logic            m_valid,
  input  logic            m_ready,
  output logic [XLEN-1:0] m_result,
  output logic [RDW-1:0]  m_rd,
  output logic [2:0]      m_cmp
);

  // Micro-op encoding; code n drives ALU op line n. Code 31 is sro.
  typedef enum logic [4:0] {
    UopAdd,  UopSub,  UopXor,   UopOr,     UopAnd,  UopSlt,   UopSltu,  UopSrl,
    UopSll,  UopSra,  UopRor,   UopRol,    UopPack, UopPackh, UopPacku, UopGrev,
    UopShfl, UopUnshfl, UopXnor, UopOrn,   UopAndn, UopClz,   UopCtz,   UopGorc,
    UopMax,  UopMaxu, UopMin,   UopMinu,   UopPcnt, UopSextb, UopSexth, UopSro
  } uop_e;

  // E1 state
  logic            e1_valid_q, e1_valid_d;
  logic [31:0]     e1_onehot_q, e1_onehot_d;
  logic [XLEN-1:0] e1_opr_a_q, e1_opr_a_d;
  logic [XLEN-1:0] e1_opr_b_q, e1_opr_b_d;
  logic [RDW-1:0]  e1_rd_q, e1_rd_d;

  // E2 state
  logic            e2_valid_q, e2_valid_d;
  logic [XLEN-1:0] e2_result_q, e2_result_d;
  logic [RDW-1:0]  e2_rd_q, e2_rd_d;
  logic [2:0]      e2_cmp_q, e2_cmp_d;

  logic        e1_adv;
  logic        accept;
  logic        e2_load;
  logic [31:0] uop_onehot;
  uop_e        uop;

  // Handshake: E1 can move on whenever E2 is empty or draining this cycle.
  always_comb begin
    e1_adv  = !e2_valid_q || m_ready;
    s_ready = (!e1_valid_q || e1_adv) && !flush;
    accept  = s_valid && s_ready;
    e2_load = e1_valid_q && e1_adv && !flush;
  end

  // Decode the 5-bit micro-op into the ALU's one-hot op lines.
  always_comb begin
    uop        = uop_e'(s_uop);
    uop_onehot = 32'd1 << uop;
  end

  // E1 next state: load on accept, otherwise clear when the op moves on so
  // the ALU inputs stop toggling while idle.
  always_comb begin
    e1_valid_d  = e1_valid_q;
    e1_onehot_d = e1_onehot_q;
    e1_opr_a_d  = e1_opr_a_q;
    e1_opr_b_d  = e1_opr_b_q;
    e1_rd_d     = e1_rd_q;
    if (flush) begin
      e1_valid_d  = 1'b0;
      e1_onehot_d = '0;
      e1_opr_a_d  = '0;
      e1_opr_b_d  = '0;
      e1_rd_d     = '0;
    end else if (accept) begin
      e1_valid_d  = 1'b1;
      e1_onehot_d = uop_onehot;
      e1_opr_a_d  = s_opr_a;
      e1_opr_b_d  = s_opr_b;
      e1_rd_d     = s_rd;
    end else if (e1_adv) begin
      e1_valid_d  = 1'b0;
      e1_onehot_d = '0;
      e1_opr_a_d  = '0;
      e1_opr_b_d  = '0;
      e1_rd_d     = '0;
    end
  end

  // E2 next state: capture ALU output as E1 advances; drop valid once taken.
  // Payload holds when not loading so writeback sees stable data under stall.
  always_comb begin
    e2_valid_d  = e2_valid_q;
    e2_result_d = e2_result_q;
    e2_rd_d     = e2_rd_q;
    e2_cmp_d    = e2_cmp_q;
    if (flush) begin
      e2_valid_d = 1'b0;
    end else if (e2_load) begin
      e2_valid_d  = 1'b1;
      e2_result_d = alu_result;
      e2_rd_d     = e1_rd_q;
      e2_cmp_d    = alu_cmp;
    end else if (m_ready) begin
      e2_valid_d = 1'b0;
    end
  end

  // E1 registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      e1_valid_q  <= 1'b0;
      e1_onehot_q <= '0;
      e1_opr_a_q  <= '0;
      e1_opr_b_q  <= '0;
      e1_rd_q     <= '0;
    end else begin
      e1_valid_q  <= e1_valid_d;
      e1_onehot_q <= e1_onehot_d;
      e1_opr_a_q  <= e1_opr_a_d;
      e1_opr_b_q  <= e1_opr_b_d;
      e1_rd_q     <= e1_rd_d;
    end
  end

  // E2 registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      e2_valid_q  <= 1'b0;
      e2_result_q <= '0;
      e2_rd_q     <= '0;
      e2_cmp_q    <= '0;
    end else begin
      e2_valid_q  <= e2_valid_d;
      e2_result_q <= e2_result_d;
      e2_rd_q     <= e2_rd_d;
      e2_cmp_q    <= e2_cmp_d;
    end
  end

  // Outputs come straight from the stage registers.
  always_comb begin
    alu_op    = e1_onehot_q;
    alu_opr_a = e1_opr_a_q;
    alu_opr_b = e1_opr_b_q;
    alu_shamt = e1_opr_b_q[4:0];
    m_valid   = e2_valid_q;
    m_result  = e2_result_q;
    m_rd      = e2_rd_q;
    m_cmp     = e2_cmp_q;
  end

endmodule

// File: tb/tb_frv_alu_issue.sv
// Scoreboard bench for frv_alu_issue with a behavioural ALU model.
module tb_frv_alu_issue;
  localparam int XLEN = 32;
  localparam int RDW  = 5;

  logic            g_clk = 1'b0;
  logic            g_resetn;
  logic            flush;
  logic            s_valid;
  logic            s_ready;
  logic [4:0]      s_uop;
  logic [XLEN-1:0] s_opr_a;
  logic [XLEN-1:0] s_opr_b;
  logic [RDW-1:0]  s_rd;
  logic [XLEN-1:0] alu_opr_a;
  logic [XLEN-1:0] alu_opr_b;
  logic [4:0]      alu_shamt;
  logic [31:0]     alu_op;
  logic [XLEN-1:0] alu_result;
  logic [2:0]      alu_cmp;
  logic            m_valid;
  logic            m_ready;
  logic [XLEN-1:0] m_result;
  logic [RDW-1:0]  m_rd;
  logic [2:0]      m_cmp;

  int errors = 0;
  int checks = 0;

  frv_alu_issue #(.XLEN(XLEN), .RDW(RDW)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_uop      (s_uop),
    .s_opr_a    (s_opr_a),
    .s_opr_b    (s_opr_b),
    .s_rd       (s_rd),
    .alu_opr_a  (alu_opr_a),
    .alu_opr_b  (alu_opr_b),
    .alu_shamt  (alu_shamt),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cmp    (alu_cmp),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_result   (m_result),
    .m_rd       (m_rd),
    .m_cmp      (m_cmp)
  );

  always #5 g_clk = ~g_clk;

  // Behavioural ALU. Bit-permutation ops use a stand-in value; the wrapper
  // never interprets results, it only has to carry the right one.
  function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] shamt);
    int sh;
    logic [31:0] r;
    sh = int'(shamt);
    case (code)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a ^ b;
      3:  r = a | b;
      4:  r = a & b;
      5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6:  r = (a < b) ? 32'd1 : 32'd0;
      7:  r = a >> sh;
      8:  r = a << sh;
      9:  r = $signed(a) >>> sh;
      10: r = (a >> sh) | (a << (32 - sh));
      11: r = (a << sh) | (a >> (32 - sh));
      12: r = {b[15:0], a[15:0]};
      13: r = {16'd0, b[7:0], a[7:0]};
      14: r = {b[31:16], a[31:16]};
      18: r = ~(a ^ b);
      19: r = a | ~b;
      20: r = a & ~b;
      21: begin
        r = 32'd32;
        for (int i = 0; i < 32; i++) if (a[i]) r = 32'(31 - i);
      end
      22: begin
        r = 32'd32;
        for (int i = 31; i >= 0; i--) if (a[i]) r = 32'(i);
      end
      24: r = ($signed(a) > $signed(b)) ? a : b;
      25: r = (a > b) ? a : b;
      26: r = ($signed(a) < $signed(b)) ? a : b;
      27: r = (a < b) ? a : b;
      28: r = 32'($countones(a));
      29: r = {{24{a[7]}}, a[7:0]};
      30: r = {{16{a[15]}}, a[15:0]};
      31: r = ~((~a) >> sh);
      default: r = a ^ (b << 1) ^ (32'(code) * 32'h0101_0101);
    endcase
    return r;
  endfunction

  // Compare flags {ltu, lt, eq} are only produced for compare-type ops.
  function automatic logic [2:0] ref_cmp(input int code, input logic [31:0] a,
                                         input logic [31:0] b);
    if (code == 5 || code == 6 || (code >= 24 && code <= 27))
      return {a < b, $signed(a) < $signed(b), a == b};
    return 3'b000;
  endfunction

  // ALU stand-in driven by the DUT's one-hot lines.
  always_comb begin
    int idx;
    int cnt;
    idx = 0;
    cnt = 0;
    alu_result = 32'hBAD0_BAD0;
    alu_cmp    = 3'b111;
    for (int i = 0; i < 32; i++) begin
      if (alu_op[i]) begin
        idx = i;
        cnt++;
      end
    end
    if (cnt == 1) begin
      alu_result = ref_alu(idx, alu_opr_a, alu_opr_b, alu_shamt);
      alu_cmp    = ref_cmp(idx, alu_opr_a, alu_opr_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an in-order queue of capacity two; an op becomes visible at the
  // head once it has been inside for two edges.
  typedef struct {
    int          code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          age;
  } item_t;

  item_t q[$];

  // Monitor: compare DUT outputs against the model, then advance the model.
  always @(negedge g_clk) begin
    bit    out_v;
    bit    exp_rdy;
    bit    e1_has;
    item_t e1;
    item_t nw;
    if (!g_resetn) begin
      q.delete();
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_alu_op", alu_op, 32'd0);
    end else begin
      out_v   = q.size() > 0 && q[0].age >= 2;
      exp_rdy = !flush && (q.size() < 2 || m_ready);
      e1_has  = 1'b0;
      e1      = '{code: 0, a: '0, b: '0, rd: '0, age: 0};
      if (q.size() > 0) begin
        if (q[0].age < 2) begin
          e1_has = 1'b1;
          e1     = q[0];
        end else if (q.size() > 1) begin
          e1_has = 1'b1;
          e1     = q[1];
        end
      end
      chk("m_valid", 32'(m_valid), 32'(out_v));
      if (out_v) begin
        chk("m_result", m_result, ref_alu(q[0].code, q[0].a, q[0].b, q[0].b[4:0]));
        chk("m_rd", 32'(m_rd), 32'(q[0].rd));
        chk("m_cmp", 32'(m_cmp), 32'(ref_cmp(q[0].code, q[0].a, q[0].b)));
      end
      chk("s_ready", 32'(s_ready), 32'(exp_rdy));
      chk("alu_op", alu_op, e1_has ? (32'd1 << e1.code) : 32'd0);
      if (e1_has) begin
        chk("alu_opr_a", alu_opr_a, e1.a);
        chk("alu_opr_b", alu_opr_b, e1.b);
        chk("alu_shamt", 32'(alu_shamt), 32'(e1.b[4:0]));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_v && m_ready) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (s_valid && exp_rdy) begin
          nw = '{code: int'(s_uop), a: s_opr_a, b: s_opr_b, rd: s_rd, age: 1};
          q.push_back(nw);
        end
      end
    end
  end

  // Present one op and hold it until the DUT takes it.
  task automatic issue(input int code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    s_valid = 1'b1;
    s_uop   = code[4:0];
    s_opr_a = a;
    s_opr_b = b;
    s_rd    = rd;
    for (int k = 0; k < 200; k++) begin
      @(negedge g_clk);
      if (s_ready) begin
        @(posedge g_clk);
        #1;
        s_valid = 1'b0;
        return;
      end
      @(posedge g_clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout: got no accept expected accept for code %0d", code);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    g_resetn = 1'b0;
    flush    = 1'b0;
    s_valid  = 1'b0;
    s_uop    = '0;
    s_opr_a  = '0;
    s_opr_b  = '0;
    s_rd     = '0;
    m_ready  = 1'b1;
    #1;
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_result", m_result, 32'd0);
    chk("reset_alu_op", alu_op, 32'd0);
    chk("reset_alu_opr_a", alu_opr_a, 32'd0);
    idle(3);
    g_resetn = 1'b1;
    idle(2);

    // Single add, then back-to-back sub/sra/sltu.
    issue(0, 32'd5, 32'd7, 5'd3);
    idle(3);
    issue(1, 32'd3, 32'd5, 5'd4);
    issue(9, 32'h8000_0000, 32'd4, 5'd5);
    issue(6, 32'd1, 32'd2, 5'd6);
    idle(4);

    // Back-pressure: two ops fill the pipe, a third waits.
    m_ready = 1'b0;
    issue(2, 32'hF0F0_1234, 32'h0FF0_4321, 5'd7);
    issue(24, 32'hFFFF_FFF0, 32'd9, 5'd8);
    s_valid = 1'b1;
    s_uop   = 5'd27;
    s_opr_a = 32'd100;
    s_opr_b = 32'd200;
    s_rd    = 5'd9;
    idle(4);
    m_ready = 1'b1;
    issue(27, 32'd100, 32'd200, 5'd9);
    idle(4);

    // Flush with both stages full and a new op offered.
    m_ready = 1'b0;
    issue(3, 32'h1111_0000, 32'h0000_2222, 5'd30);
    issue(4, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd31);
    s_valid = 1'b1;
    s_uop   = 5'd0;
    s_rd    = 5'd29;
    flush   = 1'b1;
    idle(1);
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    chk("flush_alu_op", alu_op, 32'd0);
    m_ready = 1'b1;
    idle(4);

    // Sweep every micro-op code.
    for (int c = 0; c < 32; c++) issue(c, $urandom, $urandom, 5'(c));
    idle(4);

    // Async reset with both stages valid.
    m_ready = 1'b0;
    issue(1, 32'd50, 32'd8, 5'd10);
    issue(8, 32'd1, 32'd31, 5'd11);
    #2;
    g_resetn = 1'b0;
    #1;
    chk("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk("async_rst_alu_op", alu_op, 32'd0);
    idle(2);
    g_resetn = 1'b1;
    m_ready  = 1'b1;
    idle(5);

    // Randomised traffic with random back-pressure and occasional flush.
    for (int n = 0; n < 600; n++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_uop   = 5'($urandom_range(0, 31));
      s_opr_a = $urandom;
      s_opr_b = ($urandom_range(0, 3) == 0) ? s_opr_a : $urandom;
      s_rd    = 5'($urandom_range(0, 31));
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      idle(1);
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
